// File: rtl/dec_to_bin_seq.sv
// dec_to_bin_seq: sequential converter from a five-digit BCD value to a
// 16-bit binary value with a valid/ready handshake on both sides.
//
// The FSM captures bcd_in in IDLE, runs five multiply-by-ten-and-add steps
// in CONV (most significant digit first), then presents the result in DONE
// until the consumer accepts it. Results above 65535 saturate to 16'hFFFF
// and raise err_ovf. Any nibble above 9 skips CONV and reports err_digit.
//
// Ports
//   clk        system clock, rising edge
//   clr_n      asynchronous active-low reset
//   abort      synchronous cancel back to IDLE (highest priority)
//   bcd_in     five BCD digits, [19:16] = 10^4 digit, [3:0] = units digit
//   in_valid   bcd_in is valid
//   in_ready   block can accept a value (IDLE only)
//   bin_out    converted binary value
//   out_valid  bin_out and error flags are valid (DONE only)
//   out_ready  consumer accepts the result
//   err_digit  an input nibble was greater than 9
//   err_ovf    decimal value was greater than 65535
//   busy       state is CONV or DONE
module dec_to_bin_seq (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        abort,
  input  logic [19:0] bcd_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] bin_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_digit,
  output logic        err_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q;
  logic [19:0] bcd_q;
  logic [16:0] acc_q;
  logic [16:0] acc_d;
  logic [2:0]  idx_q;
  logic [3:0]  digit;
  logic [15:0] bin_q;
  logic        out_valid_q;
  logic        in_ready_q;
  logic        busy_q;
  logic        err_digit_q;
  logic        err_ovf_q;

  // True when any of the five nibbles is not a decimal digit.
  function automatic logic has_bad_digit(input logic [19:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (v[i*4 +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // The accumulator never exceeds 99999, so bit 16 alone marks overflow.
  function automatic logic [15:0] sat_u16(input logic [16:0] a);
    return a[16] ? 16'hFFFF : a[15:0];
  endfunction

  function automatic logic is_ovf(input logic [16:0] a);
    return a[16];
  endfunction

  always_comb begin
    digit = 4'd0;
    case (idx_q)
      3'd4:    digit = bcd_q[19:16];
      3'd3:    digit = bcd_q[15:12];
      3'd2:    digit = bcd_q[11:8];
      3'd1:    digit = bcd_q[7:4];
      3'd0:    digit = bcd_q[3:0];
      default: digit = 4'd0;
    endcase
    // acc*10 = acc*8 + acc*2; max 9999*10+9 fits in 17 bits.
    acc_d = (acc_q << 3) + (acc_q << 1) + {13'd0, digit};
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= IDLE;
      bcd_q       <= 20'd0;
      acc_q       <= 17'd0;
      idx_q       <= 3'd0;
      bin_q       <= 16'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else if (abort) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // in_ready_q is low only on the first edge after reset release,
          // which delays the first acceptance by one edge.
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            bcd_q       <= bcd_in;
            acc_q       <= 17'd0;
            idx_q       <= 3'd4;
            bin_q       <= 16'd0;
            err_ovf_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (has_bad_digit(bcd_in)) begin
              state_q     <= DONE;
              err_digit_q <= 1'b1;
              out_valid_q <= 1'b1;
            end else begin
              state_q     <= CONV;
              err_digit_q <= 1'b0;
            end
          end
        end
        CONV: begin
          acc_q <= acc_d;
          if (idx_q == 3'd0) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            bin_q       <= sat_u16(acc_d);
            err_ovf_q   <= is_ovf(acc_d);
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;
  assign busy      = busy_q;

endmodule
